// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIN
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 is_div;
    logic                 is_signed;
    logic                 neg_q;
    logic                 neg_r;
    logic                 dz;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   work;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   div_next;

    assign a_neg = is_signed & a_q[WIDTH-1];
    assign b_neg = is_signed & b_q[WIDTH-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;

    // Multiply: work = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_addend = work[0] ? b_q : {WIDTH{1'b0}};
    assign mul_sum    = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, work[WIDTH-1:1]};

    // Divide: work = {partial remainder, dividend/quotient}, shifted left each step.
    // The trial subtraction is WIDTH+1 bits wide so the bit shifted out of the
    // remainder is not lost; its borrow decides restore versus keep.
    assign div_trial = work[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    assign div_next  = div_trial[WIDTH] ? {work[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            is_div      <= 1'b0;
            is_signed   <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            work        <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                    a_q       <= A;
                                    b_q       <= B;
                                    is_div    <= op[1];
                                    is_signed <= ~op[0];
                                    busy      <= 1'b1;
                                    state     <= S_PREP;
                                end
                                OP_MTHI: begin
                                    hi   <= A;
                                    done <= 1'b1;
                                end
                                OP_MTLO: begin
                                    lo   <= A;
                                    done <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_PREP: begin
                        work  <= {{WIDTH{1'b0}}, a_mag};
                        b_q   <= b_mag;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dz    <= is_div & (b_q == '0);
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                    S_RUN: begin
                        work <= is_div ? div_next : mul_next;
                        if (cnt == LAST_ITER) begin
                            cnt   <= '0;
                            state <= S_FIN;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_FIN: begin
                        // a_q still holds the raw dividend, needed for the divide-by-zero result
                        if (dz) begin
                            hi <= a_q;
                            lo <= '1;
                        end else if (is_div) begin
                            lo <= neg_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
                            hi <= neg_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
                        end else begin
                            {hi, lo} <= neg_q ? -work : work;
                        end
                        div_by_zero <= dz;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests = 0;
    int fails = 0;
    int edges = 0;
    int last_done_edge = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {div_by_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint    sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin
                p = 64'(sa * sb);
                return {1'b0, p};
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {1'b0, r[31:0], q[31:0]};
                end
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [64:0] e;
        int cyc;
        e = model(o, a, b);
        op = o; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
        check({tag, " busy"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        last_done_edge = edges;
        check({tag, " latency"}, 64'(cyc), 64'd34);
        check({tag, " hi"}, 64'(hi), 64'(e[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(e[31:0]));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(e[64]));
        check({tag, " busy_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] hi_prev, lo_prev;
        logic [64:0] e;
        int n_done, first_edge;
        logic [31:0] ra, rb;
        logic [2:0]  ro;

        #1;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset dbz", 64'(div_by_zero), 64'd0);
        #20 reset_n = 1'b1;
        tick();

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0003, "mult -1*3");
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0003, "multu");
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div -7/2");
        run_op(3'd3, 32'h0000_0007, 32'h0000_0002, "divu 7/2");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div minneg/-1");
        run_op(3'd3, 32'h0000_0005, 32'h0000_0000, "divu by0");
        tick();
        check("dbz pulse clears", 64'(div_by_zero), 64'd0);
        check("done pulse clears", 64'(done), 64'd0);
        run_op(3'd2, 32'hFFFF_FF00, 32'h0000_0000, "div by0");

        // MTHI / MTLO
        lo_prev = lo;
        op = 3'd4; A = 32'h1234_5678; start = 1'b1;
        tick();
        start = 1'b0;
        check("mthi hi", 64'(hi), 64'h1234_5678);
        check("mthi lo", 64'(lo), 64'(lo_prev));
        check("mthi done", 64'(done), 64'd1);
        check("mthi busy", 64'(busy), 64'd0);
        tick();
        check("mthi done clears", 64'(done), 64'd0);
        hi_prev = hi;
        op = 3'd5; A = 32'hCAFE_F00D; start = 1'b1;
        tick();
        start = 1'b0;
        check("mtlo lo", 64'(lo), 64'hCAFE_F00D);
        check("mtlo hi", 64'(hi), 64'(hi_prev));
        check("mtlo done", 64'(done), 64'd1);

        // reserved opcodes
        hi_prev = hi; lo_prev = lo;
        op = 3'd6; A = 32'h1111_1111; start = 1'b1;
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        n_done = 0;
        repeat (5) begin
            if (done || busy) n_done++;
            tick();
        end
        check("reserved activity", 64'(n_done), 64'd0);
        check("reserved hi", 64'(hi), 64'(hi_prev));
        check("reserved lo", 64'(lo), 64'(lo_prev));

        // flush together with start in IDLE: start dropped
        op = 3'd4; A = 32'h5555_AAAA; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush+start done", 64'(done), 64'd0);
        check("flush+start hi", 64'(hi), 64'(hi_prev));

        // second start mid-RUN ignored
        e = model(3'd2, 32'hFFFF_FF9C, 32'd7);
        op = 3'd2; A = 32'hFFFF_FF9C; B = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        op = 3'd0; A = 32'h0000_1234; B = 32'h0000_0100; start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        repeat (60) begin
            if (done) begin
                n_done++;
                check("midrun hi", 64'(hi), 64'(e[63:32]));
                check("midrun lo", 64'(lo), 64'(e[31:0]));
            end
            tick();
        end
        check("midrun done count", 64'(n_done), 64'd1);

        // flush in RUN cycle 10
        hi_prev = hi; lo_prev = lo;
        op = 3'd2; A = 32'd1000; B = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        n_done = 0;
        repeat (40) begin
            if (done) n_done++;
            tick();
        end
        check("flush no done", 64'(n_done), 64'd0);
        check("flush hi", 64'(hi), 64'(hi_prev));
        check("flush lo", 64'(lo), 64'(lo_prev));
        check("flush dbz", 64'(div_by_zero), 64'd0);

        // async reset mid-RUN
        op = 3'd0; A = 32'h0001_0001; B = 32'h0000_0777; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        #2 reset_n = 1'b0;
        #1;
        check("async rst hi", 64'(hi), 64'd0);
        check("async rst lo", 64'(lo), 64'd0);
        check("async rst busy", 64'(busy), 64'd0);
        #1 reset_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            tick();
            if (done || busy) n_done++;
        end
        check("post rst idle", 64'(n_done), 64'd0);

        // back-to-back: MULTU accepted in the done cycle of DIVU
        run_op(3'd3, 32'd100, 32'd9, "b2b divu");
        first_edge = last_done_edge;
        run_op(3'd1, 32'h8765_4321, 32'hFFFF_0001, "b2b multu");
        check("b2b spacing", 64'(last_done_edge - first_edge), 64'd35);

        // randomized operations
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(ro, ra, rb, $sformatf("rand%0d op%0d", i, ro));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
